// File: rtl/my_p0_pkg.sv
// Shared MY-P0 definitions: interrupt FSM state encoding, default vector base, device limit.
package my_p0_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } int_state_t;

  localparam logic [31:0] INT_VEC_BASE = 32'h0000_0010;
  localparam int          MAX_DEV      = 16;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: starting at i_start and wrapping, the first set
// request bit wins. With i_start tied to zero this is plain lowest-index-wins.
module int_prio_enc #(
  parameter int NUM_DEV = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_DEV-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [IDX_W-1:0]   o_win_idx,
  output logic               o_any
);

  int w_idx;

  // Scan from the farthest offset down so the nearest-to-start request is written last.
  always_comb begin
    o_win_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      w_idx = int'(i_start) + k;
      if (w_idx >= NUM_DEV) w_idx = w_idx - NUM_DEV;
      if (i_req[w_idx]) begin
        o_win_idx = IDX_W'(w_idx);
        o_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Prioritising interrupt controller: latches IRQ edges, raises on_int, returns the granted vector.
// Optional INT_CTRL_RR_EN selects rotating priority instead of fixed lowest-index-wins.
module int_controller
  import my_p0_pkg::*;
#(
  parameter int          NUM_DEV  = 4,
  parameter logic [31:0] VEC_BASE = INT_VEC_BASE,
  parameter int          IDX_W    = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DEV-1:0] dev_irq,
  input  logic               ie,
  input  logic               int_ack,
  input  logic               mask_we,
  input  logic [NUM_DEV-1:0] mask_din,
  output logic               on_int,
  output logic               vec_valid,
  output logic [31:0]        vec_out,
  output logic [NUM_DEV-1:0] dev_ack,
  output logic [NUM_DEV-1:0] pend_out
);

  int_state_t         r_state;
  logic [NUM_DEV-1:0] r_irq_q;
  logic [NUM_DEV-1:0] r_pending;
  logic [NUM_DEV-1:0] r_mask;
  logic               r_on_int;
  logic               r_vec_valid;
  logic [31:0]        r_vec_out;
  logic [NUM_DEV-1:0] r_dev_ack;

  logic [NUM_DEV-1:0] w_rise;
  logic [NUM_DEV-1:0] w_cand;
  logic               w_req;
  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_win;
  logic               w_any;
  logic               w_grant;
  logic [NUM_DEV-1:0] w_onehot;
  logic [NUM_DEV-1:0] w_clr;

`ifdef INT_CTRL_RR_EN
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_next;

  assign w_start   = r_rr_ptr;
  assign w_rr_next = (int'(w_win) + 1 >= NUM_DEV) ? '0 : w_win + IDX_W'(1);
`else
  assign w_start   = '0;
`endif

  assign w_rise  = dev_irq & ~r_irq_q;
  assign w_cand  = r_pending & r_mask;
  assign w_req   = ie & (|w_cand);
  assign w_grant = (r_state == REQ) && int_ack && w_any;
  assign w_clr   = w_grant ? w_onehot : '0;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_onehot[i] = (w_win == IDX_W'(i));
    end
  end

  int_prio_enc #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .i_req     (w_cand),
    .i_start   (w_start),
    .o_win_idx (w_win),
    .o_any     (w_any)
  );

  // The winner is captured into vec_out/dev_ack on the int_ack edge, so later arrivals cannot alter it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_irq_q     <= '0;
      r_pending   <= '0;
      r_mask      <= '1;
      r_on_int    <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_out   <= '0;
      r_dev_ack   <= '0;
`ifdef INT_CTRL_RR_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      r_irq_q     <= dev_irq;
      r_pending   <= (r_pending & ~w_clr) | w_rise;
      r_vec_valid <= 1'b0;
      r_dev_ack   <= '0;
      if (mask_we) r_mask <= mask_din;

      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state  <= REQ;
            r_on_int <= 1'b1;
          end
        end
        REQ: begin
          if (w_grant) begin
            r_state     <= ACK;
            r_on_int    <= 1'b0;
            r_vec_valid <= 1'b1;
            r_vec_out   <= VEC_BASE + 32'(w_win);
            r_dev_ack   <= w_onehot;
`ifdef INT_CTRL_RR_EN
            r_rr_ptr    <= w_rr_next;
`endif
          end else if (!w_req) begin
            r_state  <= IDLE;
            r_on_int <= 1'b0;
          end
        end
        ACK: begin
          r_state <= HOLD;
        end
        HOLD: begin
          if (!int_ack) r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_on_int <= 1'b0;
        end
      endcase
    end
  end

  assign on_int    = r_on_int;
  assign vec_valid = r_vec_valid;
  assign vec_out   = r_vec_out;
  assign dev_ack   = r_dev_ack;
  assign pend_out  = r_pending;

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller (NUM_DEV=4, VEC_BASE=32'h10).
module tb_int_controller;
  import my_p0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dev_irq;
  logic        ie;
  logic        int_ack;
  logic        mask_we;
  logic [3:0]  mask_din;
  logic        on_int;
  logic        vec_valid;
  logic [31:0] vec_out;
  logic [3:0]  dev_ack;
  logic [3:0]  pend_out;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  always #5 clk = ~clk;

  int_controller #(
    .NUM_DEV  (4),
    .VEC_BASE (32'h10),
    .IDX_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dev_irq   (dev_irq),
    .ie        (ie),
    .int_ack   (int_ack),
    .mask_we   (mask_we),
    .mask_din  (mask_din),
    .on_int    (on_int),
    .vec_valid (vec_valid),
    .vec_out   (vec_out),
    .dev_ack   (dev_ack),
    .pend_out  (pend_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dev_irq = 4'b1111; ie = 1'b0; int_ack = 1'b0;
    mask_we = 1'b0; mask_din = 4'h0;
    tick();
    chk("rst_on_int", 32'(on_int), 32'd0);
    chk("rst_vec_valid", 32'(vec_valid), 32'd0);
    chk("rst_vec_out", vec_out, 32'h0);
    chk("rst_dev_ack", 32'(dev_ack), 32'h0);
    chk("rst_pend", 32'(pend_out), 32'h0);
    chk("rst_mask", 32'(dut.r_mask), 32'hF);
    rst = 1'b0; dev_irq = 4'b0000;
    tick();

    // Single IRQ on device 2
    ie = 1'b1; dev_irq = 4'b0100;
    tick();
    chk("single_pend", 32'(pend_out), 32'h4);
    chk("single_on_int_p1", 32'(on_int), 32'd0);
    tick();
    chk("single_on_int_p2", 32'(on_int), 32'd1);
    int_ack = 1'b1;
    tick();
    chk("single_vld", 32'(vec_valid), 32'd1);
    chk("single_vec", vec_out, 32'h12);
    chk("single_ack", 32'(dev_ack), 32'h4);
    chk("single_pend_clr", 32'(pend_out), 32'h0);
    tick();
    chk("single_vld_pulse", 32'(vec_valid), 32'd0);
    chk("single_ack_pulse", 32'(dev_ack), 32'h0);
    chk("single_vec_hold", vec_out, 32'h12);
    int_ack = 1'b0;
    tick();
    dev_irq = 4'b0000;
    tick();

    // Fixed priority: devices 1 and 3 together
    dev_irq = 4'b1010;
    tick();
    tick();
    chk("prio_on_int", 32'(on_int), 32'd1);
    int_ack = 1'b1;
    tick();
    chk("prio_vec1", vec_out, 32'h11);
    chk("prio_ack1", 32'(dev_ack), 32'h2);
    chk("prio_pend1", 32'(pend_out), 32'h8);
    int_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("prio_on_int2", 32'(on_int), 32'd1);
    int_ack = 1'b1;
    tick();
    chk("prio_vec2", vec_out, 32'h13);
    chk("prio_ack2", 32'(dev_ack), 32'h8);
    int_ack = 1'b0;
    tick();
    tick();
    dev_irq = 4'b0000;
    tick();

    // Masking and ie withdrawal
    mask_we = 1'b1; mask_din = 4'b1110;
    tick();
    mask_we = 1'b0; dev_irq = 4'b0001;
    tick();
    tick();
    tick();
    chk("mask_on_int", 32'(on_int), 32'd0);
    chk("mask_pend", 32'(pend_out), 32'h1);
    mask_we = 1'b1; mask_din = 4'b1111;
    tick();
    mask_we = 1'b0;
    tick();
    chk("unmask_on_int", 32'(on_int), 32'd1);
    ie = 1'b0;
    tick();
    chk("ie_drop_on_int", 32'(on_int), 32'd0);
    chk("ie_drop_ack", 32'(dev_ack), 32'h0);
    int_ack = 1'b1;
    tick();
    chk("idle_ack_ignored_vld", 32'(vec_valid), 32'd0);
    chk("idle_ack_ignored_ack", 32'(dev_ack), 32'h0);
    int_ack = 1'b0; ie = 1'b1;
    tick();
    int_ack = 1'b1;
    tick();
    chk("mask_vec", vec_out, 32'h10);
    int_ack = 1'b0;
    tick();
    tick();
    dev_irq = 4'b0000;
    tick();

    // Held int_ack with two pending devices
    dev_irq = 4'b0011;
    tick();
    tick();
    int_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (vec_valid) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_vec", vec_out, 32'h10);
    chk("held_pend", 32'(pend_out), 32'h2);
    chk("held_on_int", 32'(on_int), 32'd0);
    int_ack = 1'b0;
    tick();
    tick();
    chk("held_on_int2", 32'(on_int), 32'd1);
    int_ack = 1'b1;
    tick();
    chk("held_vec2", vec_out, 32'h11);
    chk("held_ack2", 32'(dev_ack), 32'h2);
    int_ack = 1'b0;
    tick();
    tick();
    dev_irq = 4'b0000;
    tick();

    // Grant 0, then re-raise 0 and 1: rotation picks 1, fixed priority picks 0
    dev_irq = 4'b0001;
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    chk("rot_first_vec", vec_out, 32'h10);
    int_ack = 1'b0; dev_irq = 4'b0000;
    tick();
    tick();
    dev_irq = 4'b0011;
    tick();
    tick();
    int_ack = 1'b1;
    tick();
`ifdef INT_CTRL_RR_EN
    chk("rot_second_vec", vec_out, 32'h11);
`else
    chk("rot_second_vec", vec_out, 32'h10);
`endif
    int_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst_on_int", 32'(on_int), 32'd1);

    // Reset asserted during the ACK cycle
    int_ack = 1'b1;
    tick();
    chk("midrst_in_ack", 32'(vec_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_dev_ack", 32'(dev_ack), 32'h0);
    chk("midrst_vld", 32'(vec_valid), 32'd0);
    chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
    chk("midrst_pend", 32'(pend_out), 32'h0);
    chk("midrst_vec", vec_out, 32'h0);
    rst = 1'b0; int_ack = 1'b0; dev_irq = 4'b0000;
    tick();
    tick();
    chk("post_rst_on_int", 32'(on_int), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
